// File: rtl/dmaw_2d_seq.sv
// dmaw_2d_seq: splits one 2D write descriptor into a sequence of 1D row
// requests for the write engine, one row in flight at a time, and drives
// the descriptor status (sof/busy/done/err/row count).
module dmaw_2d_seq #(
  parameter int unsigned ROW_W = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_start,
  input  logic [31:0]      cfg_addr,
  input  logic [15:0]      cfg_row_len,
  input  logic [ROW_W-1:0] cfg_row_num,
  input  logic [31:0]      cfg_stride,
  input  logic             cfg_dma_halt,
  output logic             dma_w_req,
  input  logic             dma_w_ack,
  output logic [31:0]      dma_w_addr,
  output logic [15:0]      dma_w_len,
  input  logic             dma_w_done,
  input  logic             dma_w_err,
  output logic             dma_cmd_sof,
  output logic             dma_busy,
  output logic             dma_done,
  output logic             dma_err,
  output logic [ROW_W-1:0] row_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [31:0]      r_addr;
  logic [15:0]      r_len;
  logic [ROW_W-1:0] r_row_num;
  logic [31:0]      r_stride;
  logic [ROW_W-1:0] r_row_cnt;
  logic             r_sof;
  logic             r_done;
  logic             r_err;

  logic             w_start;
  logic             w_issue;
  logic             w_row_done;
  logic             w_last;
  logic             w_finish;

  // State register; reset drops any descriptor in progress without a done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_issue    = 1'b0;
    w_row_done = 1'b0;
    w_finish   = 1'b0;
    w_last     = (r_row_cnt == r_row_num);
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_start = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ: begin
        // Halt gates the request combinationally; state simply waits here.
        w_issue = !cfg_dma_halt;
        if (w_issue && dma_w_ack) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dma_w_done) begin
          w_row_done = 1'b1;
          if (dma_w_err || w_last) begin
            w_finish = 1'b1;
            w_next   = S_IDLE;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Descriptor latch, row address walk, row counter and status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_row_num <= '0;
      r_stride  <= '0;
      r_row_cnt <= '0;
      r_sof     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sof  <= w_start;
      r_done <= w_finish;
      if (w_start) begin
        r_addr    <= cfg_addr;
        r_len     <= cfg_row_len;
        r_row_num <= cfg_row_num;
        r_stride  <= cfg_stride;
        r_row_cnt <= '0;
        r_err     <= 1'b0;
      end
      if (w_row_done) begin
        r_row_cnt <= r_row_cnt + ROW_W'(1);
        if (dma_w_err) begin
          r_err <= 1'b1;
        end else if (!w_last) begin
          // 32-bit wrap; a two's-complement stride walks downwards.
          r_addr <= r_addr + r_stride;
        end
      end
    end
  end

  assign dma_w_req   = w_issue;
  assign dma_w_addr  = r_addr;
  assign dma_w_len   = r_len;
  assign dma_cmd_sof = r_sof;
  assign dma_busy    = (r_state != S_IDLE);
  assign dma_done    = r_done;
  assign dma_err     = r_err;
  assign row_cnt     = r_row_cnt;

endmodule

// File: tb/tb_dmaw_2d_seq.sv
// tb_dmaw_2d_seq: table of 2D descriptors driven through an engine model,
// with expected row requests queued at start and popped at each request.
module tb_dmaw_2d_seq;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_start;
  logic [31:0]   cfg_addr;
  logic [15:0]   cfg_row_len;
  logic [RW-1:0] cfg_row_num;
  logic [31:0]   cfg_stride;
  logic          cfg_dma_halt;
  logic          dma_w_req;
  logic          dma_w_ack;
  logic [31:0]   dma_w_addr;
  logic [15:0]   dma_w_len;
  logic          dma_w_done;
  logic          dma_w_err;
  logic          dma_cmd_sof;
  logic          dma_busy;
  logic          dma_done;
  logic          dma_err;
  logic [RW-1:0] row_cnt;

  dmaw_2d_seq #(.ROW_W(RW)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_addr(cfg_addr),
    .cfg_row_len(cfg_row_len), .cfg_row_num(cfg_row_num), .cfg_stride(cfg_stride),
    .cfg_dma_halt(cfg_dma_halt), .dma_w_req(dma_w_req), .dma_w_ack(dma_w_ack),
    .dma_w_addr(dma_w_addr), .dma_w_len(dma_w_len), .dma_w_done(dma_w_done),
    .dma_w_err(dma_w_err), .dma_cmd_sof(dma_cmd_sof), .dma_busy(dma_busy),
    .dma_done(dma_done), .dma_err(dma_err), .row_cnt(row_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   addr;
    logic [15:0]   len;
    logic [RW-1:0] rows;
    logic [31:0]   stride;
    int            err_row;
    logic [RW-1:0] exp_cnt;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
  } req_t;

  req_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   hs_cnt   = 0;

  // Count accepted request handshakes.
  always @(posedge clk) begin
    if (rstn && dma_w_req && dma_w_ack) hs_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int num_reqs(input vec_t v);
    return (v.err_row >= 0) ? v.err_row + 1 : int'(v.rows) + 1;
  endfunction

  // Queue the expected row requests, pulse start, check the first cycle.
  task automatic do_start(input vec_t v);
    logic [31:0] a;
    req_t r;
    a = v.addr;
    for (int i = 0; i < num_reqs(v); i++) begin
      r.addr = a;
      r.len  = v.len;
      sb.push_back(r);
      a = a + v.stride;
    end
    cfg_addr    = v.addr;
    cfg_row_len = v.len;
    cfg_row_num = v.rows;
    cfg_stride  = v.stride;
    cfg_start   = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("sof_pulse", dma_cmd_sof, 1);
    chk("busy_at_start", dma_busy, 1);
    chk("err_cleared", dma_err, 0);
  endtask

  // Engine model for one row. mode 1: raise halt while the row is in flight.
  // mode 2: pulse a conflicting start while the row is in flight.
  task automatic serve_row(input int dly, input logic err, input int mode);
    req_t e;
    for (int i = 0; i < 40 && !dma_w_req; i++) @(negedge clk);
    if (!dma_w_req) begin
      chk("req_timeout", dma_w_req, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_underflow", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    chk("req_addr", dma_w_addr, e.addr);
    chk("req_len", dma_w_len, 32'(e.len));
    @(negedge clk);
    chk("req_hold", dma_w_req, 1);
    chk("addr_stable", dma_w_addr, e.addr);
    dma_w_ack = 1'b1;
    @(negedge clk);
    dma_w_ack = 1'b0;
    chk("req_drop", dma_w_req, 0);
    if (mode == 1) cfg_dma_halt = 1'b1;
    if (mode == 2) begin
      cfg_addr    = 32'hDEAD0000;
      cfg_row_len = 16'h0001;
      cfg_row_num = 4'd5;
      cfg_stride  = 32'h4;
      cfg_start   = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      chk("busy_start_sof", dma_cmd_sof, 0);
      chk("busy_start_busy", dma_busy, 1);
    end
    repeat (dly - 1) @(negedge clk);
    dma_w_done = 1'b1;
    dma_w_err  = err;
    @(negedge clk);
    dma_w_done = 1'b0;
    dma_w_err  = 1'b0;
  endtask

  task automatic finish_check(input vec_t v);
    chk("done_pulse", dma_done, 1);
    chk("busy_end", dma_busy, 0);
    chk("row_cnt_final", 32'(row_cnt), 32'(v.exp_cnt));
    chk("err_flag", dma_err, v.exp_err);
    @(negedge clk);
    chk("done_1cycle", dma_done, 0);
    chk("no_extra_req", dma_w_req, 0);
    chk("err_sticky", dma_err, v.exp_err);
  endtask

  task automatic run_desc(input vec_t v, input int dly);
    int base;
    base = hs_cnt;
    do_start(v);
    @(negedge clk);
    chk("sof_1cycle", dma_cmd_sof, 0);
    for (int i = 0; i < num_reqs(v); i++) serve_row(dly, (i == v.err_row), 0);
    finish_check(v);
    chk("req_count", hs_cnt - base, num_reqs(v));
    chk("sb_empty", sb.size(), 0);
  endtask

  vec_t tbl[7];
  vec_t vh, vb, va, vbb, vr;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int done_seen;
    logic [RW-1:0] c0;
    logic e0;

    tbl[0] = '{32'h0000_1000, 16'h003F, 4'd0,  32'h0000_0000, -1, 4'd1, 1'b0};
    tbl[1] = '{32'h0000_0FF0, 16'h001F, 4'd2,  32'h0000_0100, -1, 4'd3, 1'b0};
    tbl[2] = '{32'h0000_0080, 16'h0010, 4'd1,  32'hFFFF_FF00, -1, 4'd2, 1'b0};
    tbl[3] = '{32'h0000_2000, 16'h0007, 4'd4,  32'h0000_0040,  1, 4'd2, 1'b1};
    tbl[4] = '{32'h0000_3000, 16'h00FF, 4'd1,  32'h0000_0020, -1, 4'd2, 1'b0};
    tbl[5] = '{32'hFFFF_FFF0, 16'h0000, 4'd15, 32'h0000_0008, -1, 4'd0, 1'b0};
    tbl[6] = '{32'h0000_0100, 16'h0080, 4'd2,  32'h0000_0040, -1, 4'd3, 1'b0};

    rstn = 1'b0; cfg_start = 1'b0; cfg_addr = '0; cfg_row_len = '0;
    cfg_row_num = '0; cfg_stride = '0; cfg_dma_halt = 1'b0;
    dma_w_ack = 1'b0; dma_w_done = 1'b0; dma_w_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", dma_w_req, 0);
    chk("rst_addr", dma_w_addr, 0);
    chk("rst_len", 32'(dma_w_len), 0);
    chk("rst_sof", dma_cmd_sof, 0);
    chk("rst_busy", dma_busy, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_err", dma_err, 0);
    chk("rst_row_cnt", 32'(row_cnt), 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 7; t++) run_desc(tbl[t], (t == 0) ? 5 : 3);

    // Ack/done/err while idle must change nothing.
    c0 = row_cnt; e0 = dma_err;
    dma_w_ack = 1'b1; dma_w_done = 1'b1; dma_w_err = 1'b1;
    repeat (2) @(negedge clk);
    dma_w_ack = 1'b0; dma_w_done = 1'b0; dma_w_err = 1'b0;
    chk("idle_busy", dma_busy, 0);
    chk("idle_req", dma_w_req, 0);
    chk("idle_done", dma_done, 0);
    chk("idle_row_cnt", 32'(row_cnt), 32'(c0));
    chk("idle_err", dma_err, e0);

    // Halt: raised during the first row, held 10 cycles over the second row's request.
    vh = '{32'h0000_4000, 16'h0010, 4'd1, 32'h0000_0200, -1, 4'd2, 1'b0};
    do_start(vh);
    @(negedge clk);
    serve_row(3, 1'b0, 1);
    chk("halt_row0_cnt", 32'(row_cnt), 1);
    chk("halt_busy", dma_busy, 1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (dma_w_req) hi++;
      @(negedge clk);
    end
    chk("halt_req_low", hi, 0);
    cfg_dma_halt = 1'b0;
    #1;
    chk("halt_release_req", dma_w_req, 1);
    chk("halt_release_addr", dma_w_addr, 32'h0000_4200);
    cfg_dma_halt = 1'b1;
    #1;
    chk("halt_comb_gate", dma_w_req, 0);
    cfg_dma_halt = 1'b0;
    #1;
    serve_row(3, 1'b0, 0);
    finish_check(vh);

    // Start while busy is ignored; the original rows complete.
    vb = '{32'h0000_5000, 16'h0020, 4'd1, 32'h0000_0100, -1, 4'd2, 1'b0};
    do_start(vb);
    @(negedge clk);
    serve_row(3, 1'b0, 2);
    serve_row(3, 1'b0, 0);
    finish_check(vb);
    chk("busy_start_sb", sb.size(), 0);

    // New start accepted in the cycle dma_done is high.
    va  = '{32'h0000_7000, 16'h0004, 4'd0, 32'h0000_0000, -1, 4'd1, 1'b0};
    vbb = '{32'h0000_7100, 16'h0008, 4'd1, 32'h0000_0010, -1, 4'd2, 1'b0};
    do_start(va);
    @(negedge clk);
    serve_row(2, 1'b0, 0);
    chk("b2b_done", dma_done, 1);
    do_start(vbb);
    @(negedge clk);
    serve_row(2, 1'b0, 0);
    serve_row(2, 1'b0, 0);
    finish_check(vbb);

    // Asynchronous reset mid-descriptor.
    vr = '{32'h0000_6000, 16'h0040, 4'd3, 32'h0000_0100, -1, 4'd4, 1'b0};
    do_start(vr);
    chk("rst_pre_req", dma_w_req, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_req", dma_w_req, 0);
    chk("arst_addr", dma_w_addr, 0);
    chk("arst_len", 32'(dma_w_len), 0);
    chk("arst_busy", dma_busy, 0);
    chk("arst_sof", dma_cmd_sof, 0);
    chk("arst_row_cnt", 32'(row_cnt), 0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (dma_done) done_seen++;
    end
    @(negedge clk);
    rstn = 1'b1;
    sb.delete();
    @(negedge clk);
    if (dma_done) done_seen++;
    chk("arst_no_done", done_seen, 0);
    chk("arst_idle_busy", dma_busy, 0);
    chk("arst_idle_req", dma_w_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
